// File: rtl/blinky_pkg.sv
// Shared definitions for the blink generator and blink monitor.
package blinky_pkg;

   localparam int CLOCK_FREQ_HZ = 125000000;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

endpackage

// File: rtl/blink_monitor_if.sv
// Measurement hand-off: the monitor offers on/off durations, the consumer accepts.
interface blink_monitor_if #(
   parameter int count_width = 28
) ();

   logic [count_width-1:0] on_clocks;
   logic [count_width-1:0] off_clocks;
   logic                   meas_valid;
   logic                   meas_ready;

   modport master (
      output on_clocks,
      output off_clocks,
      output meas_valid,
      input  meas_ready
   );

   modport slave (
      input  on_clocks,
      input  off_clocks,
      input  meas_valid,
      output meas_ready
   );

endinterface

// File: rtl/blink_monitor_input_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample filter.
// level follows din 2 + filter_clocks cycles after din changes.
module input_debounce #(
   parameter int filter_clocks = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level
);

   localparam int FW = (filter_clocks > 1) ? $clog2(filter_clocks) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(filter_clocks - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic [FW-1:0] filt_q;

   // bring the asynchronous input into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
      end
   end

   // flip level only after filter_clocks disagreeing samples in a row
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         filt_q  <= '0;
      end else if (sync2_q == level_q) begin
         filt_q <= '0;
      end else if (filt_q == FILT_LAST) begin
         level_q <= ~level_q;
         filt_q  <= '0;
      end else begin
         filt_q <= filt_q + 1'b1;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/blink_monitor.sv
// Measures high/low durations of a deglitched pulse train and offers each
// complete period on a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for a rising edge to start a clean period
// HIGH  | counting cycles with level = 1
// LOW   | counting cycles with level = 0; next rise publishes the period
module blink_monitor
   import blinky_pkg::*;
#(
   parameter int clock_freq_hz  = CLOCK_FREQ_HZ,
   parameter int filter_clocks  = 8,
   parameter int count_width    = 28,
   parameter int timeout_clocks = clock_freq_hz * 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pulse_in,
   output logic            level,
   output logic            timeout,
   output logic            overrun,
   blink_monitor_if.master meas
);

   // Counter is compared against timeout_clocks, so it can never wrap.
   if (64'(timeout_clocks) >= (64'd1 << count_width)) begin : g_bad_timeout
      $error("blink_monitor: timeout_clocks must be < 2**count_width");
   end

   localparam logic [count_width-1:0] TIMEOUT_CNT = count_width'(timeout_clocks);
   localparam logic [count_width-1:0] ONE         = count_width'(1);

   state_t                 state_q, state_d;
   logic [count_width-1:0] cnt_q, cnt_d;
   logic [count_width-1:0] pend_q, pend_d;
   logic                   level_d1_q;
   logic                   rise, fall;
   logic                   publish;
   logic                   timeout_d;

   logic [count_width-1:0] on_q, off_q;
   logic                   valid_q;
   logic                   timeout_q;
   logic                   overrun_q;

   input_debounce #(
      .filter_clocks (filter_clocks)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .din   (pulse_in),
      .level (level)
   );

   assign rise = level & ~level_d1_q;
   assign fall = ~level & level_d1_q;

   // FSM, phase counter and pending on-time registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pend_q     <= '0;
         level_d1_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         level_d1_q <= level;
      end
   end

   // next state; the counter restarts at 1 because the edge cycle belongs to the new phase
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      publish   = 1'b0;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               cnt_d   = ONE;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               pend_d  = cnt_q;
               cnt_d   = ONE;
               state_d = LOW;
            end else if (cnt_q == TIMEOUT_CNT) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         LOW: begin
            if (rise) begin
               publish = 1'b1;
               cnt_d   = ONE;
               state_d = HIGH;
            end else if (cnt_q == TIMEOUT_CNT) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // output handshake; a publish into a stalled slot is dropped and flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         on_q      <= '0;
         off_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
         if (publish) begin
            if (!valid_q || meas.meas_ready) begin
               on_q    <= pend_q;
               off_q   <= cnt_q;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && meas.meas_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign meas.on_clocks  = on_q;
   assign meas.off_clocks = off_q;
   assign meas.meas_valid = valid_q;
   assign timeout         = timeout_q;
   assign overrun         = overrun_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor with a measurement scoreboard.
module tb_blink_monitor;

   localparam int FILT = 4;
   localparam int CW   = 16;
   localparam int TMO  = 1000;

   logic clk = 1'b0;
   logic rst;
   logic pulse_in;
   logic level;
   logic timeout;
   logic overrun;

   blink_monitor_if #(.count_width(CW)) mif ();

   blink_monitor #(
      .clock_freq_hz  (125000000),
      .filter_clocks  (FILT),
      .count_width    (CW),
      .timeout_clocks (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in),
      .level    (level),
      .timeout  (timeout),
      .overrun  (overrun),
      .meas     (mif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] on;
      logic [CW-1:0] off;
   } meas_t;

   meas_t sb[$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int acc_cnt    = 0;
   int last_acc   = 0;
   int prev_acc   = 0;
   int lvl_hi     = 0;
   int to_cnt     = 0;
   int to_cyc     = 0;
   int rise_cyc   = 0;
   logic lvl_prev = 1'b0;

   int a0, l0, t0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // negedge observation: level/timeout bookkeeping and scoreboard pops on accept
   task automatic sample();
      meas_t m;
      if (!rst) begin
         if (level && !lvl_prev) rise_cyc = cyc;
         if (level) lvl_hi++;
         if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
         end
         if (mif.meas_valid && mif.meas_ready) begin
            acc_cnt++;
            prev_acc = last_acc;
            last_acc = cyc;
            if (sb.size() == 0) begin
               check("unexpected_meas", 32'(mif.on_clocks), 32'hFFFF_FFFF);
            end else begin
               m = sb.pop_front();
               check("on_clocks", 32'(mif.on_clocks), 32'(m.on));
               check("off_clocks", 32'(mif.off_clocks), 32'(m.off));
            end
         end
      end
      lvl_prev = level;
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic hold(input logic val, input int n);
      pulse_in = val;
      repeat (n) step();
   endtask

   task automatic period(input int on_n, input int off_n, input bit expect_meas);
      meas_t m;
      if (expect_meas) begin
         m.on  = CW'(on_n);
         m.off = CW'(off_n);
         sb.push_back(m);
      end
      hold(1'b1, on_n);
      hold(1'b0, off_n);
   endtask

   task automatic do_reset();
      pulse_in = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pulse_in = 1'b0;
      mif.meas_ready = 1'b0;
      @(posedge clk);
      #1;
      repeat (3) step();
      check("rst_level", 32'(level), 0);
      check("rst_on", 32'(mif.on_clocks), 0);
      check("rst_off", 32'(mif.off_clocks), 0);
      check("rst_valid", 32'(mif.meas_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_overrun", 32'(overrun), 0);
      rst = 1'b0;

      // periodic 100/400, consumer always ready
      mif.meas_ready = 1'b1;
      hold(1'b0, 20);
      a0 = acc_cnt;
      t0 = to_cnt;
      repeat (3) period(100, 400, 1'b1);
      hold(1'b1, 30);
      check("t1_accepts", 32'(acc_cnt - a0), 3);
      check("t1_sb_empty", 32'(sb.size()), 0);
      check("t1_spacing", 32'(last_acc - prev_acc), 500);
      check("t1_timeout", 32'(to_cnt - t0), 0);
      check("t1_overrun", 32'(overrun), 0);

      // 3-cycle glitch is filtered out; 4 cycles is the shortest that passes
      do_reset();
      hold(1'b0, 20);
      a0 = acc_cnt;
      l0 = lvl_hi;
      hold(1'b1, 3);
      hold(1'b0, 40);
      check("t2_glitch_level", 32'(lvl_hi - l0), 0);
      check("t2_glitch_meas", 32'(acc_cnt - a0), 0);
      hold(1'b1, 4);
      hold(1'b0, 40);
      check("t2_min_pulse_level", 32'(lvl_hi - l0), 4);
      check("t2_min_pulse_meas", 32'(acc_cnt - a0), 0);

      // stalled consumer across three 50/150 periods
      do_reset();
      mif.meas_ready = 1'b0;
      hold(1'b0, 20);
      period(50, 150, 1'b1);
      hold(1'b1, 10);
      check("t3_valid1", 32'(mif.meas_valid), 1);
      check("t3_on1", 32'(mif.on_clocks), 50);
      check("t3_off1", 32'(mif.off_clocks), 150);
      check("t3_overrun1", 32'(overrun), 0);
      hold(1'b1, 40);
      hold(1'b0, 150);
      hold(1'b1, 10);
      check("t3_overrun2", 32'(overrun), 1);
      check("t3_valid2", 32'(mif.meas_valid), 1);
      hold(1'b1, 40);
      hold(1'b0, 150);
      hold(1'b1, 10);
      check("t3_on3", 32'(mif.on_clocks), 50);
      check("t3_off3", 32'(mif.off_clocks), 150);
      a0 = acc_cnt;
      mif.meas_ready = 1'b1;
      step();
      check("t3_valid_drop", 32'(mif.meas_valid), 0);
      check("t3_accepts", 32'(acc_cnt - a0), 1);
      check("t3_sb_empty", 32'(sb.size()), 0);
      check("t3_overrun_sticky", 32'(overrun), 1);

      // long high phase abandons the measurement
      do_reset();
      mif.meas_ready = 1'b1;
      hold(1'b0, 20);
      a0 = acc_cnt;
      t0 = to_cnt;
      hold(1'b1, 1200);
      check("t4_timeout_once", 32'(to_cnt - t0), 1);
      // counter holds 1000 one cycle after level has been high 1000 cycles;
      // the registered pulse is seen the cycle after that
      check("t4_timeout_time", 32'(to_cyc - rise_cyc), 1001);
      hold(1'b0, 400);
      period(100, 400, 1'b1);
      hold(1'b1, 20);
      check("t4_accepts", 32'(acc_cnt - a0), 1);
      check("t4_sb_empty", 32'(sb.size()), 0);
      check("t4_timeout_total", 32'(to_cnt - t0), 1);

      // reset in the middle of a high phase
      do_reset();
      mif.meas_ready = 1'b0;
      hold(1'b0, 10);
      period(60, 90, 1'b0);
      hold(1'b1, 20);
      check("t5_pre_valid", 32'(mif.meas_valid), 1);
      check("t5_pre_on", 32'(mif.on_clocks), 60);
      rst = 1'b1;
      pulse_in = 1'b0;
      step();
      check("t5_level", 32'(level), 0);
      check("t5_on", 32'(mif.on_clocks), 0);
      check("t5_off", 32'(mif.off_clocks), 0);
      check("t5_valid", 32'(mif.meas_valid), 0);
      check("t5_timeout", 32'(timeout), 0);
      check("t5_overrun", 32'(overrun), 0);
      rst = 1'b0;
      mif.meas_ready = 1'b1;
      a0 = acc_cnt;
      hold(1'b0, 30);
      period(70, 130, 1'b1);
      hold(1'b1, 20);
      check("t5_accepts", 32'(acc_cnt - a0), 1);
      check("t5_sb_empty", 32'(sb.size()), 0);

      // accept of the held value in the same cycle as the next publish
      do_reset();
      mif.meas_ready = 1'b0;
      hold(1'b0, 10);
      a0 = acc_cnt;
      period(40, 60, 1'b1);
      period(30, 90, 1'b1);
      // level rises 2 + FILT edges after pulse_in; publish lands on the next edge
      pulse_in = 1'b1;
      repeat (2 + FILT) step();
      mif.meas_ready = 1'b1;
      step();
      mif.meas_ready = 1'b0;
      check("t6_valid", 32'(mif.meas_valid), 1);
      check("t6_on", 32'(mif.on_clocks), 30);
      check("t6_off", 32'(mif.off_clocks), 90);
      check("t6_overrun", 32'(overrun), 0);
      check("t6_first_accept", 32'(acc_cnt - a0), 1);
      mif.meas_ready = 1'b1;
      hold(1'b1, 10);
      check("t6_accepts", 32'(acc_cnt - a0), 2);
      check("t6_sb_empty", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/blink_monitor.md
Name: blink_monitor

Overview:
Input-side counterpart to the board's LED blink generator. Samples an asynchronous on/off pulse train (pushbutton, external blink source or looped-back LED), synchronizes and deglitches it, and measures the high and low duration of each full period in clk cycles. Each completed measurement is presented on a valid/ready interface for a downstream consumer.

Parameters:
clock_freq_hz, 125000000, clk frequency; sets the default timeout only.
filter_clocks, 8, consecutive stable synchronized samples required before the filtered level changes (>=1).
count_width, 28, width of the duration counters and outputs.
timeout_clocks, clock_freq_hz*2, maximum single high or low phase before the measurement is abandoned; must be < 2**count_width (elaboration-time check).

Ports:
clk  in  1  system clock; every register is on its rising edge.
rst  in  1  synchronous, active-high reset.
pulse_in  in  1  asynchronous input pulse train.
level  out  1  filtered, synchronized copy of pulse_in.
on_clocks  out  count_width  cycles the filtered level was 1 in the last period.
off_clocks  out  count_width  cycles the filtered level was 0 in the last period.
meas_valid  out  1  on_clocks/off_clocks hold a new measurement.
meas_ready  in  1  consumer accepts the measurement when high with meas_valid.
timeout  out  1  one-cycle pulse when a phase exceeds timeout_clocks.
overrun  out  1  sticky: a completed measurement was dropped.

Behaviour:
- Reset (rst=1 at a clk edge): synchronizer flops, filter counter, level, on_clocks, off_clocks, meas_valid, timeout, overrun all 0; FSM to IDLE. Reset mid-phase discards the partial measurement.
- Synchronizer: 2 flops. Filter: level flips only after the synchronized input has differed from level for filter_clocks consecutive cycles; any agreeing sample clears the filter count. Latency pulse_in to level = 2 + filter_clocks cycles.
- Edge: rise/fall = level differs from its one-cycle-delayed copy.
- FSM IDLE: ignore level until a rise; rise -> HIGH with phase counter restarted. A falling level in IDLE is ignored (no partial period is measured).
- FSM HIGH: count cycles with level=1; on fall, latch the count as the pending on time, restart the counter, -> LOW.
- FSM LOW: count cycles with level=0; on rise, publish pending on time and the LOW count, restart the counter, -> HIGH (back-to-back periods measured with no gap).
- Count semantics: the count equals the exact number of cycles level held the phase value; a 100-cycle high pulse reports 100.
- Timeout: if the phase counter reaches timeout_clocks in HIGH or LOW, pulse timeout for 1 cycle, -> IDLE, publish nothing. Never saturates, given the parameter check.
- Handshake: publish sets meas_valid=1 and loads both outputs in the same cycle. Outputs hold stable while meas_valid=1 and meas_ready=0. meas_valid drops the cycle after meas_valid && meas_ready, unless a new publish occurs in that same cycle.
- Simultaneous publish and accept: load the new values, meas_valid stays 1, overrun unchanged.
- Publish while meas_valid=1 and meas_ready=0: new values dropped, held values kept, overrun<=1 (cleared only by rst).
- meas_ready is ignored while meas_valid=0.

Decomposition:
- Shared package blinky_pkg: FSM state enum (IDLE, HIGH, LOW) and the default clock-frequency constant 125000000, shared with the blink generator.
- One sub-module, input_debounce (synchronizer + filter; parameter filter_clocks; ports clk, rst, din, level). Edge detection, FSM, counters and handshake stay in blink_monitor.

Test Plan:
(All with filter_clocks=4, count_width=16, timeout_clocks=1000, meas_ready=1 unless stated.)
1. After reset, periodic input 100 high / 400 low -> first meas_valid at the second filtered rise: on_clocks=100, off_clocks=400; repeats every 500 cycles; timeout and overrun stay 0.
2. 3-cycle high glitch on a low input -> level stays 0, no meas_valid, FSM stays IDLE.
3. meas_ready=0 across three periods 50/150 -> on_clocks=50, off_clocks=150 held with meas_valid=1; overrun=1 after the second publish; raising meas_ready drops meas_valid next cycle.
4. Input held high for 1200 cycles after a rise -> timeout pulses once at phase count 1000, no meas_valid; next normal 100/400 period reports 100/400.
5. rst asserted mid-HIGH for 1 cycle -> all outputs 0 the next cycle; first post-reset measurement needs a full rise-fall-rise.
6. meas_valid && meas_ready in the same cycle as a new publish -> meas_valid stays 1, new values loaded, overrun stays 0.
